// File: rtl/dc_fsm_pkg.sv
// rtl/dc_fsm_pkg.sv - shared types, widths and tag-write encodings for the data-cache control FSM
package dc_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CI_ACC,
        ST_STORE_THRU,
        ST_VICTIM_WB,
        ST_REFILL,
        ST_SPR_LOOKUP,
        ST_SPR_WB
    } dc_state_e;

    localparam int DEF_LINE_WORDS = 4;
    localparam int WORD_IDX_W     = $clog2(DEF_LINE_WORDS);

    // {valid, dirty} pairs driven onto the tag RAM
    localparam logic [1:0] TAGW_INVAL = 2'b00;
    localparam logic [1:0] TAGW_CLEAN = 2'b10;
    localparam logic [1:0] TAGW_DIRTY = 2'b11;

    function automatic int word_idx_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Address layout is {tag, index, word, byte[1:0]}
    function automatic int index_w(input int aw, input int tag_w, input int line_words);
        return aw - tag_w - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/dc_burst_cnt.sv
// rtl/dc_burst_cnt.sv - wrapping line-word pointer plus beat counter for multi-beat bursts
module dc_burst_cnt #(
    parameter int LINE_WORDS = 4,
    parameter int WIW        = $clog2(LINE_WORDS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [WIW-1:0] start_idx,
    input  logic           inc,
    input  logic [WIW-1:0] req_word,
    output logic [WIW-1:0] idx,
    output logic           last,
    output logic           match
);

    logic [WIW-1:0] idx_q, idx_d;
    logic [WIW-1:0] beats_q, beats_d;

    // Power-of-two line length makes natural overflow the modulo wrap
    always_comb begin
        idx_d   = idx_q;
        beats_d = beats_q;
        if (load) begin
            idx_d   = start_idx;
            beats_d = '0;
        end else if (inc) begin
            idx_d   = idx_q + WIW'(1);
            beats_d = beats_q + WIW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            beats_q <= '0;
        end else begin
            idx_q   <= idx_d;
            beats_q <= beats_d;
        end
    end

    assign idx   = idx_q;
    assign last  = (beats_q == WIW'(LINE_WORDS - 1));
    assign match = (idx_q == req_word);

endmodule

// File: rtl/dc_wb_fsm.sv
// rtl/dc_wb_fsm.sv - write-back data-cache control FSM with victim eviction and SPR block ops
// DC_CWF_EN: refill starts at the requested word (critical-word-first) instead of word 0.
module dc_wb_fsm
    import dc_fsm_pkg::*;
#(
    parameter int AW         = 32,
    parameter int TAG_W      = 19,
    parameter int LINE_WORDS = 4,
    parameter int SEL_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dc_en,
    input  logic             req_valid,
    input  logic             req_ci,
    input  logic             req_we,
    input  logic [SEL_W-1:0] req_sel,
    input  logic [AW-1:0]    req_addr,
    input  logic             wb_mode,
    input  logic             tag_miss,
    input  logic             tag_v,
    input  logic             tag_dirty_in,
    input  logic [TAG_W-1:0] victim_tag,
    input  logic             biu_ack,
    input  logic             biu_err,
    output logic             biu_read,
    output logic             biu_write,
    output logic             burst,
    output logic [AW-1:0]    biu_addr,
    output logic             biu_do_sel,
    output logic             dcram_di_sel,
    output logic [SEL_W-1:0] dcram_we,
    output logic             tag_we,
    output logic             tag_valid,
    output logic             tag_dirty,
    output logic             hit_ack,
    output logic             miss_ack,
    output logic             miss_err,
    input  logic             spr_we,
    input  logic             spr_flush,
    input  logic             spr_wb,
    input  logic [AW-1:0]    spr_addr,
    output logic             spr_done
);

    localparam int WIW   = word_idx_w(LINE_WORDS);
    localparam int IDX_W = index_w(AW, TAG_W, LINE_WORDS);

    dc_state_e        state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             we_q, we_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             hit_q, hit_d;
    logic             acked_q, acked_d;
    logic             flush_q, flush_d;
    logic             spr_wb_q, spr_wb_d;

    logic             cnt_load, cnt_inc, cnt_last, cnt_match;
    logic [WIW-1:0]   cnt_start, cnt_idx, refill_start;
    logic [WIW-1:0]   req_word;
    logic [IDX_W-1:0] line_idx;
    logic [TAG_W-1:0] req_tag;

    assign req_word = addr_q[WIW+1:2];
    assign line_idx = addr_q[AW-TAG_W-1:WIW+2];
    assign req_tag  = addr_q[AW-1:AW-TAG_W];

`ifdef DC_CWF_EN
    assign refill_start = req_word;
`else
    assign refill_start = '0;
`endif

    dc_burst_cnt #(
        .LINE_WORDS(LINE_WORDS),
        .WIW       (WIW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .start_idx(cnt_start),
        .inc      (cnt_inc),
        .req_word (req_word),
        .idx      (cnt_idx),
        .last     (cnt_last),
        .match    (cnt_match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            hit_q    <= 1'b0;
            acked_q  <= 1'b0;
            flush_q  <= 1'b0;
            spr_wb_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            hit_q    <= hit_d;
            acked_q  <= acked_d;
            flush_q  <= flush_d;
            spr_wb_q <= spr_wb_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        sel_d        = sel_q;
        hit_d        = hit_q;
        acked_d      = acked_q;
        flush_d      = flush_q;
        spr_wb_d     = spr_wb_q;
        cnt_load     = 1'b0;
        cnt_inc      = 1'b0;
        cnt_start    = '0;
        biu_read     = 1'b0;
        biu_write    = 1'b0;
        burst        = 1'b0;
        biu_addr     = '0;
        biu_do_sel   = 1'b0;
        dcram_di_sel = 1'b0;
        dcram_we     = '0;
        tag_we       = 1'b0;
        tag_valid    = 1'b0;
        tag_dirty    = 1'b0;
        hit_ack      = 1'b0;
        miss_ack     = 1'b0;
        miss_err     = 1'b0;
        spr_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (spr_we) begin
                    addr_d   = spr_addr;
                    flush_d  = spr_flush;
                    spr_wb_d = spr_wb;
                    state_d  = ST_SPR_LOOKUP;
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    sel_d   = req_sel;
                    hit_d   = 1'b0;
                    acked_d = 1'b0;
                    state_d = (req_ci || !dc_en) ? ST_CI_ACC : ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                if (!tag_miss) begin
                    if (!we_q) begin
                        hit_ack = 1'b1;
                        state_d = ST_IDLE;
                    end else if (wb_mode) begin
                        dcram_we               = sel_q;
                        tag_we                 = 1'b1;
                        {tag_valid, tag_dirty} = TAGW_DIRTY;
                        hit_ack                = 1'b1;
                        state_d                = ST_IDLE;
                    end else begin
                        dcram_we = sel_q;
                        hit_d    = 1'b1;
                        state_d  = ST_STORE_THRU;
                    end
                end else if (tag_v && tag_dirty_in && wb_mode) begin
                    cnt_load = 1'b1;
                    state_d  = ST_VICTIM_WB;
                end else if (!we_q || wb_mode) begin
                    cnt_load  = 1'b1;
                    cnt_start = refill_start;
                    state_d   = ST_REFILL;
                end else begin
                    state_d = ST_STORE_THRU;
                end
            end

            ST_CI_ACC, ST_STORE_THRU: begin
                biu_addr  = addr_q;
                biu_read  = (state_q == ST_CI_ACC) && !we_q;
                biu_write = (state_q == ST_STORE_THRU) || we_q;
                if (biu_err) begin
                    miss_err = 1'b1;
                    state_d  = ST_IDLE;
                end else if (biu_ack) begin
                    hit_ack  = (state_q == ST_STORE_THRU) && hit_q;
                    miss_ack = !((state_q == ST_STORE_THRU) && hit_q);
                    state_d  = ST_IDLE;
                end
            end

            ST_VICTIM_WB, ST_SPR_WB: begin
                burst      = 1'b1;
                biu_write  = 1'b1;
                biu_do_sel = 1'b1;
                biu_addr   = {victim_tag, line_idx, cnt_idx, 2'b00};
                // An error leaves the tag alone so the line stays dirty
                if (biu_err) begin
                    miss_err = (state_q == ST_VICTIM_WB);
                    spr_done = (state_q == ST_SPR_WB);
                    state_d  = ST_IDLE;
                end else if (biu_ack) begin
                    cnt_inc = 1'b1;
                    if (cnt_last && state_q == ST_VICTIM_WB) begin
                        cnt_load  = 1'b1;
                        cnt_start = refill_start;
                        state_d   = ST_REFILL;
                    end else if (cnt_last) begin
                        tag_we                 = 1'b1;
                        {tag_valid, tag_dirty} = TAGW_CLEAN;
                        spr_done               = 1'b1;
                        state_d                = ST_IDLE;
                    end
                end
            end

            ST_REFILL: begin
                burst    = 1'b1;
                biu_read = 1'b1;
                biu_addr = {req_tag, line_idx, cnt_idx, 2'b00};
                // Merge beat: datapath takes LSU bytes for sel_q, BIU bytes elsewhere
                dcram_di_sel = !(we_q && cnt_match);
                if (biu_err) begin
                    tag_we                 = 1'b1;
                    {tag_valid, tag_dirty} = TAGW_INVAL;
                    miss_err               = !acked_q;
                    state_d                = ST_IDLE;
                end else if (biu_ack) begin
                    dcram_we = '1;
                    cnt_inc  = 1'b1;
                    if (cnt_match && !acked_q) begin
                        miss_ack = 1'b1;
                        acked_d  = 1'b1;
                    end
                    if (cnt_last) begin
                        tag_we                 = 1'b1;
                        {tag_valid, tag_dirty} = (we_q && wb_mode) ? TAGW_DIRTY : TAGW_CLEAN;
                        state_d                = ST_IDLE;
                    end
                end
            end

            ST_SPR_LOOKUP: begin
                if (flush_q) begin
                    tag_we                 = 1'b1;
                    {tag_valid, tag_dirty} = TAGW_INVAL;
                    spr_done               = 1'b1;
                    state_d                = ST_IDLE;
                end else if (spr_wb_q && tag_v && tag_dirty_in) begin
                    cnt_load = 1'b1;
                    state_d  = ST_SPR_WB;
                end else begin
                    spr_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dc_wb_fsm.sv
// tb/tb_dc_wb_fsm.sv - directed self-checking bench for dc_wb_fsm
module tb_dc_wb_fsm;

    localparam int AW = 32, TAG_W = 19, LINE_WORDS = 4, SEL_W = 4;
`ifdef DC_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, dc_en, req_valid, req_ci, req_we, wb_mode;
    logic [SEL_W-1:0] req_sel;
    logic [AW-1:0]    req_addr, spr_addr;
    logic             tag_miss, tag_v, tag_dirty_in, biu_ack, biu_err;
    logic [TAG_W-1:0] victim_tag;
    logic             spr_we, spr_flush, spr_wb;
    logic             biu_read, biu_write, burst, biu_do_sel, dcram_di_sel;
    logic [AW-1:0]    biu_addr;
    logic [SEL_W-1:0] dcram_we;
    logic             tag_we, tag_valid, tag_dirty, hit_ack, miss_ack, miss_err, spr_done;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dc_wb_fsm #(.AW(AW), .TAG_W(TAG_W), .LINE_WORDS(LINE_WORDS), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .dc_en(dc_en), .req_valid(req_valid), .req_ci(req_ci),
        .req_we(req_we), .req_sel(req_sel), .req_addr(req_addr), .wb_mode(wb_mode),
        .tag_miss(tag_miss), .tag_v(tag_v), .tag_dirty_in(tag_dirty_in), .victim_tag(victim_tag),
        .biu_ack(biu_ack), .biu_err(biu_err), .biu_read(biu_read), .biu_write(biu_write),
        .burst(burst), .biu_addr(biu_addr), .biu_do_sel(biu_do_sel), .dcram_di_sel(dcram_di_sel),
        .dcram_we(dcram_we), .tag_we(tag_we), .tag_valid(tag_valid), .tag_dirty(tag_dirty),
        .hit_ack(hit_ack), .miss_ack(miss_ack), .miss_err(miss_err), .spr_we(spr_we),
        .spr_flush(spr_flush), .spr_wb(spr_wb), .spr_addr(spr_addr), .spr_done(spr_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        #1;
        chk(tag, {biu_read, biu_write, burst, tag_we, hit_ack, miss_ack, miss_err, spr_done, dcram_we}, 0);
    endtask

    task automatic start_req(input logic [31:0] a, input logic we, input logic [3:0] sel, input logic ci);
        req_valid = 1'b1; req_addr = a; req_we = we; req_sel = sel; req_ci = ci;
        chk_quiet("idle_out");
        tick();
        req_valid = 1'b0;
    endtask

    task automatic lookup(input logic miss, input logic v, input logic d);
        tag_miss = miss; tag_v = v; tag_dirty_in = d;
    endtask

    task automatic refill(input logic [31:0] a, input logic st, input int err_beat);
        logic [1:0] rw, w, st0;
        logic       acked;
        rw = a[3:2];
        st0 = CWF ? rw : 2'd0;
        acked = 1'b0;
        for (int b = 0; b < 4; b++) begin
            logic e;
            e = (b == err_beat);
            w = st0 + 2'(b);
            biu_ack = !e; biu_err = e;
            #1;
            chk("rf_rd", {biu_read, burst}, 2'b11);
            chk("rf_addr", biu_addr, {a[31:4], w, 2'b00});
            chk("rf_dcram_we", dcram_we, e ? 0 : 4'hF);
            chk("rf_di_sel", dcram_di_sel, !(st && w == rw));
            chk("rf_miss_ack", miss_ack, !e && w == rw);
            chk("rf_miss_err", miss_err, e && !acked);
            chk("rf_tag_we", tag_we, e || b == 3);
            chk("rf_tag_v", tag_valid, !e && b == 3);
            chk("rf_tag_d", tag_dirty, !e && b == 3 && st);
            if (!e && w == rw) acked = 1'b1;
            tick();
            if (e) break;
        end
        biu_ack = 1'b0; biu_err = 1'b0;
    endtask

    task automatic wb_burst(input logic [18:0] vt, input logic [31:0] a, input logic spr);
        for (int b = 0; b < 4; b++) begin
            biu_ack = 1'b1;
            #1;
            chk("wb_wr", {biu_write, biu_do_sel, burst, biu_read}, 4'b1110);
            chk("wb_addr", biu_addr, {vt, a[12:4], 2'(b), 2'b00});
            chk("wb_tag_we", tag_we, spr && b == 3);
            chk("wb_tag_v", {tag_valid, tag_dirty}, (spr && b == 3) ? 2'b10 : 2'b00);
            chk("wb_spr_done", spr_done, spr && b == 3);
            tick();
        end
        biu_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dc_en = 1'b1; req_valid = 1'b0; req_ci = 1'b0; req_we = 1'b0; wb_mode = 1'b1;
        req_sel = '0; req_addr = '0; spr_addr = '0; tag_miss = 1'b0; tag_v = 1'b0;
        tag_dirty_in = 1'b0; biu_ack = 1'b0; biu_err = 1'b0; victim_tag = '0;
        spr_we = 1'b0; spr_flush = 1'b0; spr_wb = 1'b0;
        tick();
        chk_quiet("rst_out");
        chk("rst_addr", biu_addr, 0);
        rst = 1'b0;
        tick();

        // load hit
        start_req(32'h100, 1'b0, 4'hF, 1'b0);
        lookup(1'b0, 1'b1, 1'b0);
        #1;
        chk("hit_ack", hit_ack, 1);
        chk("hit_no_biu", {biu_read, biu_write, miss_ack}, 0);
        tick();
        chk_quiet("hit_after");

        // load miss, clean victim, with one stalled cycle before the first beat
        start_req(32'h108, 1'b0, 4'hF, 1'b0);
        lookup(1'b1, 1'b1, 1'b0);
        #1;
        chk("lm_lookup", {biu_read, hit_ack, dcram_we}, 0);
        tick();
        #1;
        chk("lm_stall_addr", biu_addr, CWF ? 32'h108 : 32'h100);
        chk("lm_stall_ack", {miss_ack, dcram_we}, 0);
        tick();
        refill(32'h108, 1'b0, -1);
        chk_quiet("lm_done");

        // store miss, write-back, dirty victim tag 0x3
        victim_tag = 19'h3;
        start_req(32'h208, 1'b1, 4'h3, 1'b0);
        lookup(1'b1, 1'b1, 1'b1);
        #1;
        chk("sm_lookup_we", dcram_we, 0);
        tick();
        wb_burst(19'h3, 32'h208, 1'b0);
        refill(32'h208, 1'b1, -1);
        chk_quiet("sm_done");

        // refill error after the requested word was acked, then before
        start_req(32'h300, 1'b0, 4'hF, 1'b0);
        lookup(1'b1, 1'b1, 1'b0);
        tick();
        refill(32'h300, 1'b0, 1);
        chk_quiet("err1_idle");
        start_req(32'h30C, 1'b0, 4'hF, 1'b0);
        lookup(1'b1, 1'b1, 1'b0);
        tick();
        refill(32'h30C, 1'b0, 0);
        chk_quiet("err0_idle");

        // SPR write-back and LSU request together: SPR first
        spr_we = 1'b1; spr_wb = 1'b1; spr_addr = 32'h400;
        req_valid = 1'b1; req_addr = 32'h410; req_we = 1'b0; req_ci = 1'b0;
        chk_quiet("spr_idle");
        tick();
        spr_we = 1'b0; spr_wb = 1'b0;
        victim_tag = 19'h5;
        lookup(1'b0, 1'b1, 1'b1);
        #1;
        chk("spr_lookup", {spr_done, hit_ack, tag_we, burst}, 0);
        tick();
        wb_burst(19'h5, 32'h400, 1'b1);
        chk_quiet("spr_then_idle");
        tick();
        req_valid = 1'b0;
        lookup(1'b0, 1'b1, 1'b0);
        #1;
        chk("spr_req_hit", hit_ack, 1);
        tick();

        // reset during beat 3 of a refill
        start_req(32'h500, 1'b0, 4'hF, 1'b0);
        lookup(1'b1, 1'b1, 1'b0);
        tick();
        biu_ack = 1'b1;
        tick();
        tick();
        biu_ack = 1'b0;
        #1;
        chk("rst_mid_before", biu_read, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_read", {biu_read, burst, tag_we}, 0);
        chk("rst_mid_addr", biu_addr, 0);
        tick();
        rst = 1'b0;
        chk_quiet("rst_release");
        tick();
        start_req(32'h500, 1'b0, 4'hF, 1'b0);
        lookup(1'b0, 1'b1, 1'b0);
        #1;
        chk("rst_then_hit", hit_ack, 1);
        tick();

        // cache-inhibited load
        start_req(32'h604, 1'b0, 4'hF, 1'b1);
        #1;
        chk("ci_rd", {biu_read, biu_write, burst, miss_ack}, 4'b1000);
        chk("ci_addr", biu_addr, 32'h604);
        tick();
        biu_ack = 1'b1;
        #1;
        chk("ci_ack", miss_ack, 1);
        tick();
        biu_ack = 1'b0;

        // cache disabled store with BIU error
        dc_en = 1'b0;
        start_req(32'h700, 1'b1, 4'hF, 1'b0);
        biu_err = 1'b1;
        #1;
        chk("dis_err", {biu_write, biu_read, miss_err, miss_ack}, 4'b1010);
        tick();
        biu_err = 1'b0; dc_en = 1'b1;

        // store hit, write-through
        wb_mode = 1'b0;
        start_req(32'h800, 1'b1, 4'h4, 1'b0);
        lookup(1'b0, 1'b1, 1'b0);
        #1;
        chk("wt_hit_we", {dcram_we, tag_we, hit_ack}, 6'b0100_00);
        tick();
        biu_ack = 1'b1;
        #1;
        chk("wt_hit_done", {biu_write, biu_do_sel, hit_ack, miss_ack}, 4'b1010);
        chk("wt_hit_addr", biu_addr, 32'h800);
        tick();
        biu_ack = 1'b0;

        // store hit, write-back
        wb_mode = 1'b1;
        start_req(32'h900, 1'b1, 4'h1, 1'b0);
        lookup(1'b0, 1'b1, 1'b0);
        #1;
        chk("wb_hit", {dcram_we, tag_we, tag_valid, tag_dirty, hit_ack}, 8'b0001_1111);
        tick();

        // store miss, write-through: no allocate
        wb_mode = 1'b0;
        start_req(32'hA04, 1'b1, 4'h2, 1'b0);
        lookup(1'b1, 1'b1, 1'b0);
        #1;
        chk("wt_miss_lookup", {dcram_we, burst}, 0);
        tick();
        biu_ack = 1'b1;
        #1;
        chk("wt_miss_done", {biu_write, burst, miss_ack, hit_ack}, 4'b1010);
        tick();
        biu_ack = 1'b0; wb_mode = 1'b1;

        // SPR flush, then SPR write-back of a clean line
        spr_we = 1'b1; spr_flush = 1'b1; spr_addr = 32'hB00;
        tick();
        spr_we = 1'b0; spr_flush = 1'b0;
        #1;
        chk("flush", {tag_we, tag_valid, tag_dirty, spr_done}, 4'b1001);
        tick();
        spr_we = 1'b1; spr_wb = 1'b1;
        tick();
        spr_we = 1'b0; spr_wb = 1'b0;
        lookup(1'b0, 1'b1, 1'b0);
        #1;
        chk("spr_wb_clean", {spr_done, burst, tag_we}, 3'b100);
        tick();
        chk_quiet("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dc_wb_fsm.md
Name: dc_wb_fsm

Overview:
Parametrised next-generation data-cache control FSM for the OR1200-class LSU path. It sits between the LSU request port, the tag/data RAMs and the BIU. Line length, address width and tag width are configurable. The block adds write-back with dirty-victim eviction, write-allocate, wrapped refill bursts and an SPR block-writeback operation.

Parameters:
AW, 32, address width
TAG_W, 19, tag width
LINE_WORDS, 4, words per line; power of 2, >=2
SEL_W, 4, byte enables per word

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
dc_en  in  1  cache enable; 0 makes every request cache-inhibited
req_valid  in  1  LSU request (cyc&stb)
req_ci  in  1  cache-inhibit
req_we  in  1  store
req_sel  in  SEL_W  byte enables
req_addr  in  AW  request address
wb_mode  in  1  1 = write-back, 0 = write-through
tag_miss  in  1  tag compare miss; valid in LOOKUP
tag_v  in  1  stored line valid
tag_dirty_in  in  1  stored line dirty
victim_tag  in  TAG_W  stored tag
biu_ack  in  1  BIU beat done
biu_err  in  1  BIU beat error
biu_read  out  1  BIU read request
biu_write  out  1  BIU write request
burst  out  1  multi-beat transfer in progress
biu_addr  out  AW  BIU word address
biu_do_sel  out  1  1 = BIU write data from dcram, 0 = from LSU
dcram_di_sel  out  1  1 = dcram data from BIU, 0 = from LSU
dcram_we  out  SEL_W  data RAM byte write enables
tag_we  out  1  tag write strobe
tag_valid  out  1  tag valid written
tag_dirty  out  1  tag dirty written
hit_ack  out  1  hit completion pulse
miss_ack  out  1  miss/CI completion pulse
miss_err  out  1  error completion pulse
spr_we  in  1  SPR write strobe
spr_flush  in  1  SPR op = invalidate
spr_wb  in  1  SPR op = write back
spr_addr  in  AW  SPR target address
spr_done  out  1  SPR op complete pulse

Behaviour:
- Reset: all outputs 0; state IDLE; burst counter 0. Asserting rst mid-burst drops biu_read/biu_write immediately. No tag write occurs for an interrupted line.
- States: IDLE, LOOKUP, CI_ACC, STORE_THRU, VICTIM_WB, REFILL, SPR_LOOKUP, SPR_WB.
- IDLE:
  - spr_we has priority over req_valid when both are set; capture spr_addr -> SPR_LOOKUP.
  - Otherwise req_valid captures addr/we/sel. If req_ci or !dc_en -> CI_ACC, else -> LOOKUP.
- CI_ACC: single beat, burst=0; biu_read=!we, biu_write=we. On biu_ack: miss_ack=1. On biu_err: miss_err=1. Either -> IDLE.
- LOOKUP (1 cycle):
  - Load hit: hit_ack=1 -> IDLE.
  - Store hit, wb_mode=1: dcram_we=sel; tag_we=1, valid=1, dirty=1; hit_ack=1 -> IDLE.
  - Store hit, wb_mode=0: dcram_we=sel -> STORE_THRU.
  - Miss with tag_v & tag_dirty_in & wb_mode -> VICTIM_WB.
  - Other miss: load, or store with wb_mode=1 (write-allocate) -> REFILL.
  - Store miss with wb_mode=0 -> STORE_THRU, no allocate.
- STORE_THRU: single beat, biu_write=1, biu_do_sel=0. On biu_ack: miss_ack=1 (hit_ack=1 if it entered from a hit) -> IDLE. On biu_err: miss_err=1 -> IDLE.
- VICTIM_WB:
  - LINE_WORDS beats, burst=1, biu_write=1, biu_do_sel=1.
  - biu_addr = {victim_tag, index, cnt, 2'b00}.
  - Counter advances on biu_ack; after the last ack -> REFILL.
  - biu_err: miss_err=1 -> IDLE; tag untouched, line stays dirty.
- REFILL:
  - LINE_WORDS beats, burst=1, biu_read=1, dcram_di_sel=1, dcram_we=all-ones per ack.
  - Word counter wraps modulo LINE_WORDS.
  - miss_ack pulses on the beat whose word index equals the request word, exactly once per refill.
  - A store miss merges LSU bytes on that beat: dcram_di_sel=0 for sel bytes.
  - Last ack: tag_we=1, valid=1, dirty=(store & wb_mode) -> IDLE.
  - biu_err on any beat: if not yet acked, miss_err=1; tag_we=1 with valid=0 -> IDLE.
- SPR_LOOKUP:
  - Flush: tag_we=1, valid=0, dirty=0; spr_done=1 -> IDLE.
  - Write-back with tag_v & tag_dirty_in -> SPR_WB. Otherwise spr_done=1 -> IDLE.
- SPR_WB: burst write as in VICTIM_WB. On completion: tag_we=1, valid=1, dirty=0; spr_done=1. On error: spr_done=1, no tag write.
- Completion outputs (hit_ack, miss_ack, miss_err, spr_done) are single-cycle pulses; at most one is asserted per cycle.

Optional Feature:
DC_CWF_EN
- Defined: critical-word-first. REFILL starts at the request word and wraps, so miss_ack occurs on the first beat.
- Undefined: REFILL starts at word 0, and miss_ack occurs on beat (request word + 1).
- Beat count and final tag write are identical in both cases.

Decomposition:
- dc_fsm_pkg holds:
  - state enum
  - WORD_IDX_W = $clog2(LINE_WORDS)
  - index-width function from AW/TAG_W/LINE_WORDS
  - tag-write encoding constants
- Sub-module dc_burst_cnt provides:
  - load of start index
  - increment on ack, modulo LINE_WORDS
  - beat count with last flag
  - match flag (current == request word)

Test Plan:
- Load hit, addr 0x100 -> hit_ack exactly 1 cycle after req_valid; no BIU activity.
- Load miss, clean line, LINE_WORDS=4, addr 0x108, DC_CWF_EN defined -> biu_addr 0x108, 0x10C, 0x100, 0x104. miss_ack on beat 1; tag_we valid=1, dirty=0 after beat 4.
- Store miss, wb_mode=1, dirty victim with victim_tag 0x3 -> 4 write beats to the victim address, then 4 read beats. LSU bytes merged; final tag dirty=1.
- Refill with biu_err on beat 2 after CWF ack -> no miss_err; tag_we valid=0; back to IDLE.
- spr_we+spr_wb and req_valid in the same cycle on a dirty line -> SPR served first: 4 write beats, tag dirty=0, spr_done. The request is then served.
- rst asserted on beat 3 of a refill -> biu_read=0 immediately; no tag_we; IDLE after release.
